// File: rtl/xpb_reduce_accum.sv
// Sequential xpb reduction: walks the upper product digits one per cycle, presents
// (chunk, digit) to the xpb LUT bank and accumulates the returned multiples onto the lower bits.
module xpb_reduce_accum #(
   parameter int NUM_CHUNKS = 8,
   parameter int DIGIT_W    = 5,
   parameter int DATA_W     = 1024,
   parameter int GUARD_W    = 6,
   parameter int IDX_W      = 6
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_W-1:0]               in_lower,
   input  logic [NUM_CHUNKS*DIGIT_W-1:0]   in_upper,
   output logic [IDX_W-1:0]                lut_chunk,
   output logic [DIGIT_W-1:0]              lut_digit,
   input  logic [DATA_W-1:0]               lut_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [DATA_W+GUARD_W-1:0]       out_result
);

   localparam int ACC_W = DATA_W + GUARD_W;
   localparam int UP_W  = NUM_CHUNKS * DIGIT_W;
   localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // valid never depends on ready, and out_result is held while out_valid is high.
   state_t            state;
   logic [UP_W-1:0]   shreg;
   logic [IDX_W-1:0]  cnt;
   logic [ACC_W-1:0]  acc;

   // The LUT select comes straight from the registers, so it is glitch-free and
   // keeps its last value once accumulation ends.
   assign lut_chunk  = cnt;
   assign lut_digit  = shreg[DIGIT_W-1:0];
   assign out_result = acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         acc       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc      <= {{GUARD_W{1'b0}}, in_lower};
                  shreg    <= in_upper;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               acc <= acc + {{GUARD_W{1'b0}}, lut_data};
               // Zero digits still take their cycle so the latency is fixed.
               if (cnt == LAST_CNT) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  shreg <= shreg >> DIGIT_W;
                  cnt   <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xpb_reduce_accum.sv
// Bench for xpb_reduce_accum: LUT model, vector table, random ops against a
// sum-of-multiples reference, and hand-written backpressure / mid-op reset sequences.
module tb_xpb_reduce_accum;

   localparam int NC     = 8;
   localparam int DW     = 5;
   localparam int DATA_W = 1024;
   localparam int GW     = 6;
   localparam int IW     = 6;
   localparam int UW     = NC * DW;
   localparam int AW     = DATA_W + GW;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_lower;
   logic [UW-1:0]     in_upper;
   logic [IW-1:0]     lut_chunk;
   logic [DW-1:0]     lut_digit;
   logic [DATA_W-1:0] lut_data;
   logic              out_valid;
   logic              out_ready;
   logic [AW-1:0]     out_result;

   int errors;
   int checks;
   int lut_mode;
   logic [DATA_W-1:0] lut_tab [NC][32];

   xpb_reduce_accum #(
      .NUM_CHUNKS(NC), .DIGIT_W(DW), .DATA_W(DATA_W), .GUARD_W(GW), .IDX_W(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_lower(in_lower), .in_upper(in_upper),
      .lut_chunk(lut_chunk), .lut_digit(lut_digit), .lut_data(lut_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- LUT model ----------------
   function automatic logic [DATA_W-1:0] lut_model(input int mode, input int c, input int d);
      logic [DATA_W-1:0] v;
      v = '0;
      case (mode)
         0: v[15:0] = 16'(d * (c + 1));
         1: v = '1;
         default: v = (c < NC) ? lut_tab[c][d] : '0;
      endcase
      return v;
   endfunction

   assign lut_data = lut_model(lut_mode, int'(lut_chunk), int'(lut_digit));

   // Reference: lower plus the sum of the multiples selected by each digit.
   function automatic logic [AW-1:0] ref_sum(input logic [DATA_W-1:0] lo,
                                             input logic [UW-1:0] up, input int mode);
      logic [AW-1:0] s;
      s = AW'(lo);
      for (int i = 0; i < NC; i++)
         s = s + AW'(lut_model(mode, i, int'(up[i*DW +: DW])));
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] rand_wide();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_idle(input string name);
      chk({name, ".in_ready"}, AW'(in_ready), AW'(1));
      chk({name, ".out_valid"}, AW'(out_valid), AW'(0));
      chk({name, ".out_result"}, out_result, '0);
      chk({name, ".lut_chunk"}, AW'(lut_chunk), '0);
      chk({name, ".lut_digit"}, AW'(lut_digit), '0);
   endtask

   // ---------------- driver ----------------
   // Runs one operation: accept, per-cycle LUT select check, latency check,
   // optional backpressure hold with an ignored in_valid pulse, then drain.
   task automatic run_op(input string name, input logic [DATA_W-1:0] lo,
                         input logic [UW-1:0] up, input logic [AW-1:0] exp, input int hold);
      int waited;
      logic [AW-1:0] exp_q[$];
      exp_q.push_back(exp);
      @(negedge clk);
      chk({name, ".accept_ready"}, AW'(in_ready), AW'(1));
      in_lower = lo;
      in_upper = up;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < NC; i++) begin
         chk({name, ".lut_chunk"}, AW'(lut_chunk), AW'(i));
         chk({name, ".lut_digit"}, AW'(lut_digit), AW'(up[i*DW +: DW]));
         chk({name, ".busy_ready"}, AW'(in_ready), AW'(0));
         chk({name, ".early_valid"}, AW'(out_valid), AW'(0));
         @(negedge clk);
      end
      chk({name, ".latency"}, AW'(out_valid), AW'(1));
      waited = 0;
      while (!out_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!out_valid) begin
         errors++;
         checks++;
         $display("FAIL %s.timeout: got out_valid=0 expected 1", name);
         return;
      end
      for (int h = 0; h < hold; h++) begin
         chk({name, ".hold_valid"}, AW'(out_valid), AW'(1));
         chk({name, ".hold_ready"}, AW'(in_ready), AW'(0));
         chk({name, ".hold_result"}, out_result, exp_q[0]);
         if (h == 3) begin
            in_lower = rand_wide();
            in_upper = UW'({$urandom, $urandom});
            in_valid = 1'b1;
         end
         @(negedge clk);
         in_valid = 1'b0;
      end
      chk({name, ".result"}, out_result, exp_q.pop_front());
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, ".drain_valid"}, AW'(out_valid), AW'(0));
      chk({name, ".drain_ready"}, AW'(in_ready), AW'(1));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string             name;
      logic [DATA_W-1:0] lower;
      logic [UW-1:0]     upper;
      int                mode;
      logic [AW-1:0]     exp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [UW-1:0]     u;
      logic [DATA_W-1:0] ones;
      logic [DATA_W-1:0] lo;

      errors = 0;
      checks = 0;
      lut_mode = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_lower = '0;
      in_upper = '0;
      for (int c = 0; c < NC; c++)
         for (int d = 0; d < 32; d++) lut_tab[c][d] = rand_wide();

      ones = '1;
      vecs[0] = '{"zero_upper", DATA_W'(5), '0, 0, AW'(5)};
      for (int i = 0; i < NC; i++) u[i*DW +: DW] = 5'd1;
      vecs[1] = '{"digits_one", '0, u, 0, AW'(36)};
      vecs[2] = '{"max_mag", ones, u, 1, (AW'(ones) << 3) + AW'(ones)};
      vecs[3] = '{"digits_31", DATA_W'(100), '1, 0, AW'(100 + 31 * 36)};
      for (int i = 0; i < NC; i++) u[i*DW +: DW] = 5'(i + 1);
      vecs[4] = '{"digits_ramp", '0, u, 0, AW'(204)};

      // reset then idle
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk_idle("reset_idle");
      end

      foreach (vecs[v]) begin
         lut_mode = vecs[v].mode;
         run_op(vecs[v].name, vecs[v].lower, vecs[v].upper, vecs[v].exp, 0);
      end

      // backpressure, then the next operand must complete normally
      lut_mode = 2;
      lo = rand_wide();
      u = UW'({$urandom, $urandom});
      run_op("backpressure", lo, u, ref_sum(lo, u, 2), 10);
      lo = rand_wide();
      u = UW'({$urandom, $urandom});
      run_op("after_bp", lo, u, ref_sum(lo, u, 2), 0);

      // reset in the middle of accumulation
      @(negedge clk);
      in_lower = rand_wide();
      in_upper = '1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_idle("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("post_reset");
      lo = rand_wide();
      u = UW'({$urandom, $urandom});
      run_op("after_reset", lo, u, ref_sum(lo, u, 2), 0);

      // randomized operations across LUT modes
      for (int r = 0; r < 20; r++) begin
         lut_mode = (r % 3 == 0) ? 0 : 2;
         lo = rand_wide();
         u = UW'({$urandom, $urandom});
         run_op("random", lo, u, ref_sum(lo, u, lut_mode), int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
